flash_sample_reader: RTL
========================

// Module: flash_sample_reader
// PURPOSE
//  Downstream consumer of the clock_sync read strobe. On each synchronised ~22 kHz strobe it emits
//  one 16-bit audio sample. Samples come from 32-bit flash words read over an Avalon-MM style port.
//  Each word holds two samples, so one flash read serves two strobes.
//  Sits between the strobe synchroniser and the audio output path, in the CLOCK_50 domain.
// PARAMETERS
//  ADDR_W      23         flash word-address width
//  START_ADDR  23'h0      first word of the sample region
//  END_ADDR    23'h7FFFF  last word of the sample region (inclusive); END_ADDR > START_ADDR
// PORTS
//  CLOCK_50             in   1       system clock; only clock domain
//  reset_n              in   1       asynchronous reset, active-low
//  read_now             in   1       1-cycle sample strobe from clock_sync
//  play                 in   1       1 = accept strobes; 0 = paused
//  restart              in   1       1-cycle pulse: return to start of region
//  direction            in   1       1 = reverse playback; port present only with REVERSE_PLAY_EN
//  flash_read           out  1       Avalon read request
//  flash_address        out  ADDR_W  word address of current read
//  flash_waitrequest    in   1       slave stall; request held while high
//  flash_readdata       in   32      read data
//  flash_readdatavalid  in   1       read data valid, any cycle count after accept
//  sample_out           out  16      current sample; holds between updates
//  sample_valid         out  1       1-cycle pulse when sample_out updates
//  missed_strobe        out  1       1-cycle pulse: read_now dropped because block busy
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, flash_read=0, flash_address=START_ADDR,
//   sample_out=0, sample_valid=0, missed_strobe=0, half_sel=0, restart_pend=0.
//   flash_read drops immediately on reset even mid-transaction.
//  FSM states: IDLE, REQ, WAIT_DATA.
//  IDLE + read_now + play + half_sel=0 -> REQ.
//  IDLE + read_now + play + half_sel=1 -> next cycle: sample_out=word_buf second half,
//   sample_valid=1, half_sel=0, address advances; stay IDLE. Latency is 1 clock.
//  REQ: flash_read=1, flash_address stable. Stay while flash_waitrequest=1. Leave for WAIT_DATA
//   on the first cycle with waitrequest=0; flash_read is 0 in WAIT_DATA.
//  WAIT_DATA: on readdatavalid, word_buf<=flash_readdata. Next cycle: sample_out=first half,
//   sample_valid=1, half_sel=1, state -> IDLE.
//   Minimum latency is 3 clocks: strobe in cycle 0, REQ in cycle 1 with waitrequest=0,
//   readdatavalid in cycle 2, sample_valid in cycle 3.
//  Forward order: first half=[15:0], second=[31:16]. Address +1 after the second half.
//   After END_ADDR wraps to START_ADDR.
//  read_now while state!=IDLE: strobe dropped, missed_strobe pulses the next cycle, no other effect.
//  read_now with play=0: ignored; no missed_strobe. play=0 never aborts an in-flight read.
//  restart in IDLE: next cycle address=START_ADDR (END_ADDR if reversed), half_sel=0.
//  restart in REQ/WAIT_DATA: set restart_pend. The transaction completes and its data is
//   discarded (no sample_valid). Restart is applied on entry to IDLE.
//  restart coincident with read_now in IDLE: restart wins and the strobe is dropped (no missed_strobe).
//  sample_valid and missed_strobe are never high for more than 1 consecutive cycle.
// CONFIGURATION
//  REVERSE_PLAY_EN defined: direction port exists.
//   direction is sampled only on IDLE->REQ with half_sel=0, so a word is never split.
//   Reverse order: first half=[31:16], second=[15:0]. Address -1 after the second half.
//   START_ADDR wraps to END_ADDR. Restart in reverse loads END_ADDR.
//  REVERSE_PLAY_EN undefined: no direction port; forward only.
// TESTING
//  1 Reset, play=1, word@0=32'hBBBB_AAAA, zero wait, 1-cycle data -> strobe1: sample_valid at +3,
//    sample_out=16'hAAAA. strobe2: sample_valid at +1, 16'hBBBB, no flash_read, addr=1.
//  2 flash_waitrequest high 5 cycles -> flash_read and address held 6 cycles;
//    sample_valid at +8 relative to the strobe.
//  3 Strobe at END_ADDR second half -> flash_address=START_ADDR; next strobe reads START_ADDR.
//  4 Strobe while in WAIT_DATA -> missed_strobe=1 for 1 cycle, single sample_valid only.
//    play=0 strobes -> no sample_valid, no missed_strobe.
//  5 restart during WAIT_DATA -> no sample_valid for that read. Next strobe reads START_ADDR
//    and outputs its first half.
//  6 REVERSE_PLAY_EN, direction=1 at START_ADDR, word=32'hBBBB_AAAA -> outputs 16'hBBBB then
//    16'hAAAA, then address=END_ADDR.
//    reset_n low mid-REQ -> flash_read=0 the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/flash_sample_reader.sv
// flash_sample_reader: turns each synchronised sample strobe into one 16-bit audio
// sample. Samples are packed two per 32-bit flash word, read over an Avalon-MM style
// port, so one flash read serves two strobes. Single clock domain (CLOCK_50).
// Optional feature: define REVERSE_PLAY_EN to add the direction port and reverse playback.
module flash_sample_reader #(
  parameter int unsigned       ADDR_W     = 23,
  parameter logic [ADDR_W-1:0] START_ADDR = '0,
  parameter logic [ADDR_W-1:0] END_ADDR   = 23'h7FFFF
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              read_now,
  input  logic              play,
  input  logic              restart,
`ifdef REVERSE_PLAY_EN
  input  logic              direction,
`endif
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       sample_out,
  output logic              sample_valid,
  output logic              missed_strobe
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_DATA
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              half_sel_q, half_sel_d;     // 1 = second half of word_buf still to play
  logic              restart_pend_q, restart_pend_d;
  logic [31:0]       word_buf_q, word_buf_d;
  logic [15:0]       sample_q, sample_d;
  logic              sample_valid_q, sample_valid_d;
  logic              missed_q, missed_d;
  logic              rev_q, rev_d;               // playback direction latched for the buffered word
  logic              dir_in;

`ifdef REVERSE_PLAY_EN
  assign dir_in = direction;
`else
  assign dir_in = 1'b0;
`endif

  // Step the word address one position in the given direction, wrapping at the region ends.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, input logic rev);
    if (rev) return (a == START_ADDR) ? END_ADDR : a - 1'b1;
    else     return (a == END_ADDR)   ? START_ADDR : a + 1'b1;
  endfunction

  // Select the upper or lower 16 bits of a flash word.
  function automatic logic [15:0] pick_half(input logic [31:0] w, input logic upper);
    return upper ? w[31:16] : w[15:0];
  endfunction

  // Next-state and output decode for the read FSM.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d        = state_q;
    addr_d         = addr_q;
    half_sel_d     = half_sel_q;
    restart_pend_d = restart_pend_q;
    word_buf_d     = word_buf_q;
    sample_d       = sample_q;
    sample_valid_d = 1'b0;
    missed_d       = 1'b0;
    rev_d          = rev_q;
    flash_read     = 1'b0;

    // A played strobe that arrives while a read is in flight is dropped and reported.
    if (read_now && play && (state_q != S_IDLE)) missed_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (restart) begin
          addr_d         = dir_in ? END_ADDR : START_ADDR;
          half_sel_d     = 1'b0;
          restart_pend_d = 1'b0;
          rev_d          = dir_in;
        end else if (read_now && play) begin
          if (!half_sel_q) begin
            // Direction is only taken at a word boundary so a word is never split.
            state_d = S_REQ;
            rev_d   = dir_in;
          end else begin
            sample_d       = pick_half(word_buf_q, !rev_q);
            sample_valid_d = 1'b1;
            half_sel_d     = 1'b0;
            addr_d         = step_addr(addr_q, rev_q);
          end
        end
      end

      S_REQ: begin
        flash_read = 1'b1;
        if (restart) restart_pend_d = 1'b1;
        if (!flash_waitrequest) state_d = S_WAIT_DATA;
      end

      S_WAIT_DATA: begin
        if (restart) restart_pend_d = 1'b1;
        if (flash_readdatavalid) begin
          word_buf_d = flash_readdata;
          state_d    = S_IDLE;
          if (restart_pend_q || restart) begin
            // The read is allowed to finish but its data is thrown away.
            addr_d         = dir_in ? END_ADDR : START_ADDR;
            half_sel_d     = 1'b0;
            restart_pend_d = 1'b0;
            rev_d          = dir_in;
          end else begin
            sample_d       = pick_half(flash_readdata, rev_q);
            sample_valid_d = 1'b1;
            half_sel_d     = 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= S_IDLE;
      addr_q         <= START_ADDR;
      half_sel_q     <= 1'b0;
      restart_pend_q <= 1'b0;
      // NOTE: word_buf is plain data and never read before a fill, but resetting it keeps
      // simulation free of X and costs nothing for a single word.
      word_buf_q     <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      missed_q       <= 1'b0;
      rev_q          <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q        <= state_d;
      addr_q         <= addr_d;
      half_sel_q     <= half_sel_d;
      restart_pend_q <= restart_pend_d;
      word_buf_q     <= word_buf_d;
      sample_q       <= sample_d;
      sample_valid_q <= sample_valid_d;
      missed_q       <= missed_d;
      rev_q          <= rev_d;
    end
  end

  assign flash_address = addr_q;
  assign sample_out    = sample_q;
  assign sample_valid  = sample_valid_q;
  assign missed_strobe = missed_q;

endmodule
